// File: rtl/uart_receiver.sv
// UART receive path: synchronises rx, finds the start edge and samples every
// bit at mid-period, then presents each byte with a one-clock strobe.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshake: data_valid is a one-clock strobe with no back-pressure. The
  // consumer captures data_out/frame_error in that cycle; data_out then holds
  // until the next frame completes.

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic                   rx_m;
  logic                   rx_s;
  logic [SW-1:0]          s_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;

  // Flops reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              s_cnt <= '0;
            end
          end
          START: begin
            if (s_cnt == S_MID) begin
              // A start bit that is high again at its centre was a glitch.
              if (!rx_s) begin
                state   <= DATA;
                s_cnt   <= '0;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          DATA: begin
            if (s_cnt == S_LAST) begin
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              s_cnt <= '0;
              if (bit_cnt == B_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          STOP: begin
            // Leaving at mid stop bit lets a back-to-back start edge be seen.
            if (s_cnt == S_LAST) begin
              data_out    <= shift;
              data_valid  <= 1'b1;
              frame_error <= ~rx_s;
              state       <= IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: an 8-bit instance on a divided tick and a 7-bit
// instance with tick tied high, each checked by a queue-based scoreboard.
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int GAP      = 24;
  localparam int LAT_A    = (OS / 2 + (8 + 1) * OS) * TICK_DIV;
  localparam int LAT_B    = (OS / 2 + (7 + 1) * OS) * 1;

  logic       clk;
  logic       reset_n;
  logic       tick_a, rx_a, valid_a, ferr_a, busy_a;
  logic [7:0] data_a;
  logic [1:0] st_a;
  logic       tick_b, rx_b, valid_b, ferr_b, busy_b;
  logic [6:0] data_b;
  logic [1:0] st_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tcnt  = 0;

  // {frame_error, data} expected per strobe
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[8];

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick_a), .rx(rx_a),
    .data_out(data_a), .data_valid(valid_a), .frame_error(ferr_a),
    .busy(busy_a), .state_dbg(st_a)
  );

  uart_receiver #(.DATA_BITS(7), .OVERSAMPLE(OS)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick_b), .rx(rx_b),
    .data_out(data_b), .data_valid(valid_b), .frame_error(ferr_b),
    .busy(busy_b), .state_dbg(st_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tick_a = 1'b0;
    forever begin
      @(negedge clk);
      tick_a = (tcnt == TICK_DIV - 1);
      tcnt   = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (sel == 0) begin
        while (!tick_a) @(posedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input logic stop_bit);
    drive_rx(sel, 1'b0);
    wait_ticks(sel, OS);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(sel, d[i]);
      wait_ticks(sel, OS);
    end
    drive_rx(sel, stop_bit);
    wait_ticks(sel, OS);
    drive_rx(sel, 1'b1);
  endtask

  // scoreboard for instance a
  initial begin
    logic       busy_q  = 1'b0;
    logic       valid_q = 1'b0;
    int         start_c = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (busy_a && !busy_q) start_c = cyc;
      busy_q = busy_a;
      if (valid_q) check("valid_width_a", valid_a, 1'b0);
      valid_q = valid_a;
      if (valid_a) begin
        if (exp_a.size() == 0) begin
          check("spurious_valid_a", valid_a, 1'b0);
        end else begin
          e = exp_a.pop_front();
          check("data_a", data_a, e[7:0]);
          check("ferr_a", ferr_a, e[8]);
          check("busy_at_valid_a", busy_a, 1'b0);
          check("latency_a", cyc - start_c, LAT_A);
        end
      end
    end
  end

  // scoreboard for instance b
  initial begin
    logic       busy_q  = 1'b0;
    logic       valid_q = 1'b0;
    int         start_c = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (busy_b && !busy_q) start_c = cyc;
      busy_q = busy_b;
      if (valid_q) check("valid_width_b", valid_b, 1'b0);
      valid_q = valid_b;
      if (valid_b) begin
        if (exp_b.size() == 0) begin
          check("spurious_valid_b", valid_b, 1'b0);
        end else begin
          e = exp_b.pop_front();
          check("data_b", data_b, e[6:0]);
          check("ferr_b", ferr_b, e[8]);
          check("latency_b", cyc - start_c, LAT_B);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_a"},  data_a,  8'h00);
    check({tag, "_valid_a"}, valid_a, 1'b0);
    check({tag, "_ferr_a"},  ferr_a,  1'b0);
    check({tag, "_busy_a"},  busy_a,  1'b0);
    check({tag, "_state_a"}, st_a,    2'd0);
    check({tag, "_data_b"},  data_b,  7'h00);
    check({tag, "_busy_b"},  busy_b,  1'b0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, exp_data: 8'h3C, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h01, stop_bit: 1'b1, exp_data: 8'h01, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'hFF, stop_bit: 1'b0, exp_data: 8'hFF, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'h96, stop_bit: 1'b1, exp_data: 8'h96, exp_ferr: 1'b0};
    vecs[6].data = 8'($urandom_range(0, 255));
    vecs[6].stop_bit = 1'b1;
    vecs[6].exp_data = vecs[6].data;
    vecs[6].exp_ferr = 1'b0;
    vecs[7].data = 8'($urandom_range(0, 255));
    vecs[7].stop_bit = 1'b1;
    vecs[7].exp_data = vecs[7].data;
    vecs[7].exp_ferr = 1'b0;

    reset_n = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    tick_b  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_ticks(0, 4);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back({vecs[i].exp_ferr, vecs[i].exp_data});
      send_frame(0, {1'b0, vecs[i].data}, 8, vecs[i].stop_bit);
      wait_ticks(0, GAP);
      check("idle_busy_a", busy_a, 1'b0);
      check("idle_state_a", st_a, 2'd0);
      check("hold_data_a", data_a, vecs[i].exp_data);
    end

    // short low pulse on rx: start bit rejected at its centre
    drive_rx(0, 1'b0);
    wait_ticks(0, 3);
    check("glitch_busy_hi_a", busy_a, 1'b1);
    drive_rx(0, 1'b1);
    wait_ticks(0, 12);
    check("glitch_busy_lo_a", busy_a, 1'b0);

    // back-to-back frames with no idle between them
    exp_a.push_back({1'b0, 8'h00});
    exp_a.push_back({1'b0, 8'hFF});
    send_frame(0, 9'h000, 8, 1'b1);
    send_frame(0, 9'h0FF, 8, 1'b1);
    wait_ticks(0, GAP);
    check("b2b_hold_a", data_a, 8'hFF);

    // break: line held low for a whole frame and a bit
    exp_a.push_back({1'b1, 8'h00});
    drive_rx(0, 1'b0);
    wait_ticks(0, 10 * OS);
    drive_rx(0, 1'b1);
    wait_ticks(0, GAP);
    check("break_busy_a", busy_a, 1'b0);

    // reset during data bit 4 of 0x5A, then a clean 0x81
    drive_rx(0, 1'b0);
    wait_ticks(0, OS);
    for (int i = 0; i < 4; i++) begin
      drive_rx(0, (8'h5A >> i) & 8'h01);
      wait_ticks(0, OS);
    end
    drive_rx(0, 1'b1);
    wait_ticks(0, OS / 2);
    check("pre_reset_busy_a", busy_a, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    drive_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(0, GAP);
    check("post_reset_busy_a", busy_a, 1'b0);
    exp_a.push_back({1'b0, 8'h81});
    send_frame(0, 9'h081, 8, 1'b1);
    wait_ticks(0, GAP);
    check("post_reset_data_a", data_a, 8'h81);

    // 7-bit instance with tick tied high
    exp_b.push_back({1'b0, 1'b0, 7'h55});
    send_frame(1, 9'h055, 7, 1'b1);
    wait_ticks(1, 2 * OS);
    check("hold_data_b", data_b, 7'h55);
    exp_b.push_back({1'b1, 1'b0, 7'h2A});
    send_frame(1, 9'h02A, 7, 1'b0);
    wait_ticks(1, 2 * OS);
    exp_b.push_back({1'b0, 1'b0, 7'h7F});
    send_frame(1, 9'h07F, 7, 1'b1);
    wait_ticks(1, 2 * OS);
    check("idle_busy_b", busy_b, 1'b0);

    // final report
    check("pending_a", exp_a.size(), 0);
    check("pending_b", exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
